cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//   Run/step/halt sequencer for the 8-bit cpu on the Mimas V2 top level. Converts raw board
//   buttons into a one-cycle clock-enable (o_cpu_ce) and a CPU reset. Modes: free-run at a
//   prescaled rate, or single-step per button press. Stops the CPU on its HLT flag.
// PARAMETERS
//   DIV         50_000_000  i_clk cycles per CPU step in RUNNING (>=1; 1 = ce every cycle)
//   DEBOUNCE    1_000_000   consecutive stable cycles needed before a button level is accepted (>=1)
//   RST_CYCLES  4           length of o_cpu_rst pulse in RESET state (>=1)
// PORTS
//   i_clk        in   1  system clock; all logic on rising edge
//   i_rst        in   1  synchronous, active-high block reset
//   i_btn_run    in   1  raw async button, active-high; each press toggles run/pause
//   i_btn_step   in   1  raw async button, active-high; each press = one CPU step while paused
//   i_btn_reset  in   1  raw async button, active-high; each press resets the CPU
//   i_halt       in   1  CPU HLT flag, synchronous to i_clk, level
//   o_cpu_ce     out  1  registered one-cycle CPU clock enable
//   o_cpu_rst    out  1  registered CPU reset, active-high
//   o_state      out  2  0=RESET 1=PAUSED 2=RUNNING 3=HALTED (for LEDs)
// BEHAVIOUR
//   Reset (i_rst=1): o_cpu_ce=0, o_cpu_rst=1, o_state=RESET, prescaler/RESET counter=0,
//     synchronisers + debounced levels=0, no press pulses. i_rst mid-operation aborts everything.
//   Button path (per button): 2-flop synchroniser -> debouncer -> rising-edge detect.
//     Debounced level updates once sync output has differed from it DEBOUNCE consecutive cycles;
//     any agreeing cycle clears the count. Press pulse = 1 cycle, registered. Raw rise to press
//     pulse = DEBOUNCE+3 cycles. Releases produce no pulse. Holding = one pulse only.
//   Event priority, same cycle: i_rst > reset press > i_halt > run press > step press.
//   RESET: o_cpu_rst=1, o_cpu_ce=0 for RST_CYCLES cycles, then PAUSED. Entered from i_rst, or
//     from any state on reset press (counter restarts if already in RESET).
//   PAUSED: o_cpu_rst=0. i_halt=1 -> HALTED. Run press -> RUNNING, prescaler=0. Step press ->
//     o_cpu_ce=1 on the next cycle only; stay PAUSED.
//   RUNNING: prescaler counts 0..DIV-1, wraps. o_cpu_ce=1 for the cycle after count==DIV-1,
//     so first ce DIV cycles after entering, then every DIV cycles. Step press ignored. Run
//     press -> PAUSED, prescaler cleared, no ce. i_halt=1 -> HALTED next cycle; a ce due that
//     cycle is suppressed.
//   HALTED: o_cpu_ce=0 permanently; run/step ignored; i_halt deassertion does not exit;
//     only reset press or i_rst -> RESET.
//   o_cpu_ce is never high in two consecutive cycles unless DIV=1 in RUNNING.
//   o_state is registered and equals current state; it changes on the same edge as o_cpu_rst.
// TESTING (DIV=4, DEBOUNCE=3, RST_CYCLES=2)
//   Release i_rst -> o_cpu_rst high exactly 2 cycles, then o_state=1, o_cpu_ce stays 0.
//   Step held 10 cycles in PAUSED -> one o_cpu_ce pulse, 7 cycles after raw rise; 2-cycle
//     glitch on step -> no pulse.
//   Run press -> o_state=2, ce at 4,8,12 cycles after entry; second run press -> o_state=1,
//     no further ce.
//   i_halt=1 in RUNNING -> o_state=3 next cycle, no ce; run/step presses ignored; reset
//     press -> o_state=0, o_cpu_rst 2 cycles, o_state=1.
//   Run and reset pressed same cycle in PAUSED -> RESET; i_rst during RUNNING -> all outputs
//     at reset values on next edge.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: debounced board buttons drive a one-cycle CPU
// clock enable and a CPU reset pulse, with free-run and single-step modes.
module cpu_run_ctrl #(
    parameter int unsigned DIV        = 50_000_000,
    parameter int unsigned DEBOUNCE   = 1_000_000,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_run,
    input  logic       i_btn_step,
    input  logic       i_btn_reset,
    input  logic       i_halt,
    output logic       o_cpu_ce,
    output logic       o_cpu_rst,
    output logic [1:0] o_state
);

    localparam int unsigned PW = $clog2(DIV + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);
    localparam int unsigned RW = $clog2(RST_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);

    localparam int BTN_RUN   = 0;
    localparam int BTN_STEP  = 1;
    localparam int BTN_RESET = 2;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_RUNNING = 2'd2,
        ST_HALTED  = 2'd3
    } state_e;

    logic [2:0]    raw;
    logic [2:0]    sync1_q;
    logic [2:0]    sync2_q;
    logic [2:0]    level_q;
    logic [2:0]    level_d;
    logic [2:0]    prev_q;
    logic [2:0]    press_q;
    logic [DW-1:0] dcnt_q [3];
    logic [DW-1:0] dcnt_d [3];

    state_e        state_q;
    logic          ce_q;
    logic          rst_q;
    logic [PW-1:0] presc_q;
    logic [RW-1:0] rcnt_q;

    assign raw = {i_btn_reset, i_btn_step, i_btn_run};

    // A level is accepted only after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            level_d[i] = level_q[i];
            dcnt_d[i]  = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            prev_q  <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
            for (int i = 0; i < 3; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RESET;
            ce_q    <= 1'b0;
            rst_q   <= 1'b1;
            presc_q <= '0;
            rcnt_q  <= '0;
        end else begin
            ce_q <= 1'b0;
            if (press_q[BTN_RESET]) begin
                state_q <= ST_RESET;
                rst_q   <= 1'b1;
                rcnt_q  <= '0;
                presc_q <= '0;
            end else begin
                unique case (state_q)
                    ST_RESET: begin
                        if (rcnt_q == RST_LAST) begin
                            state_q <= ST_PAUSED;
                            rst_q   <= 1'b0;
                        end else begin
                            rcnt_q <= rcnt_q + RW'(1);
                        end
                    end
                    ST_PAUSED: begin
                        if (i_halt) begin
                            state_q <= ST_HALTED;
                        end else if (press_q[BTN_RUN]) begin
                            state_q <= ST_RUNNING;
                            presc_q <= '0;
                        end else if (press_q[BTN_STEP]) begin
                            ce_q <= 1'b1;
                        end
                    end
                    ST_RUNNING: begin
                        // Halt wins over a ce falling due in the same cycle.
                        if (i_halt) begin
                            state_q <= ST_HALTED;
                            presc_q <= '0;
                        end else if (press_q[BTN_RUN]) begin
                            state_q <= ST_PAUSED;
                            presc_q <= '0;
                        end else if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            ce_q    <= 1'b1;
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    ST_HALTED: begin
                        state_q <= ST_HALTED;
                    end
                    default: begin
                        state_q <= ST_RESET;
                        rst_q   <= 1'b1;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_cpu_ce  = ce_q;
    assign o_cpu_rst = rst_q;
    assign o_state   = state_q;

endmodule
